// File: rtl/time_keeper_if.sv
// rtl/time_keeper_if.sv - control, set-digit and running-time signals of the time keeper
// Optional TIME_12H_EN adds set_pm / pm.
interface time_keeper_if;
  logic       run;
  logic       load;
  logic [3:0] set_h1, set_h0, set_m1, set_m0;
  logic [3:0] h1, h0, m1, m0, s1, s0;
  logic       sec_pulse;
  logic       load_err;
`ifdef TIME_12H_EN
  logic       set_pm;
  logic       pm;

  modport master (output run, load, set_h1, set_h0, set_m1, set_m0, set_pm,
                  input  h1, h0, m1, m0, s1, s0, sec_pulse, load_err, pm);
  modport slave  (input  run, load, set_h1, set_h0, set_m1, set_m0, set_pm,
                  output h1, h0, m1, m0, s1, s0, sec_pulse, load_err, pm);
`else
  modport master (output run, load, set_h1, set_h0, set_m1, set_m0,
                  input  h1, h0, m1, m0, s1, s0, sec_pulse, load_err);
  modport slave  (input  run, load, set_h1, set_h0, set_m1, set_m0,
                  output h1, h0, m1, m0, s1, s0, sec_pulse, load_err);
`endif
endinterface

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - prescaled BCD running-time core with validated digit load
// Optional TIME_12H_EN selects 12-hour display with pm flag instead of 24-hour.
module time_keeper #(
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic           clk,
  input  logic           reset,
  time_keeper_if.slave   bus
);
  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic {STOPPED, RUNNING} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    h1_q, h0_q, m1_q, m0_q, s1_q, s0_q;
  logic [3:0]    h1_d, h0_d, m1_d, m0_d, s1_d, s0_d;
  logic          sec_pulse_q, sec_pulse_d;
  logic          load_err_q, load_err_d;
  logic          pm_q, pm_d;
  logic          set_pm_in;
  logic          tick;
  logic          load_ok;
  logic          min_ok;

  assign tick   = (state_q == RUNNING) && (pre_q == PRE_LAST);
  assign min_ok = (bus.set_m1 <= 4'd5) && (bus.set_m0 <= 4'd9);

`ifdef TIME_12H_EN
  localparam logic [3:0] RST_H1 = 4'd1;
  localparam logic [3:0] RST_H0 = 4'd2;
  assign set_pm_in = bus.set_pm;
  assign load_ok = min_ok &&
                   (((bus.set_h1 == 4'd0) && (bus.set_h0 != 4'd0) && (bus.set_h0 <= 4'd9)) ||
                    ((bus.set_h1 == 4'd1) && (bus.set_h0 <= 4'd2)));
  assign bus.pm  = pm_q;
`else
  localparam logic [3:0] RST_H1 = 4'd0;
  localparam logic [3:0] RST_H0 = 4'd0;
  assign set_pm_in = 1'b0;
  assign load_ok = min_ok && (bus.set_h1 <= 4'd2) && (bus.set_h0 <= 4'd9) &&
                   !((bus.set_h1 == 4'd2) && (bus.set_h0 > 4'd3));
`endif

  always_comb begin
    state_d     = bus.run ? RUNNING : STOPPED;
    pre_d       = pre_q;
    h1_d        = h1_q;
    h0_d        = h0_q;
    m1_d        = m1_q;
    m0_d        = m0_q;
    s1_d        = s1_q;
    s0_d        = s0_q;
    pm_d        = pm_q;
    sec_pulse_d = 1'b0;
    load_err_d  = 1'b0;

    if (state_q == RUNNING) pre_d = tick ? '0 : pre_q + PW'(1);

    // Full carry chain resolves in one edge, so 23:59:59 wraps in a single cycle.
    if (tick) begin
      sec_pulse_d = 1'b1;
      if (s0_q != 4'd9) s0_d = s0_q + 4'd1;
      else begin
        s0_d = 4'd0;
        if (s1_q != 4'd5) s1_d = s1_q + 4'd1;
        else begin
          s1_d = 4'd0;
          if (m0_q != 4'd9) m0_d = m0_q + 4'd1;
          else begin
            m0_d = 4'd0;
            if (m1_q != 4'd5) m1_d = m1_q + 4'd1;
            else begin
              m1_d = 4'd0;
`ifdef TIME_12H_EN
              if (h1_q == 4'd1 && h0_q == 4'd1) begin
                h0_d = 4'd2;
                pm_d = ~pm_q;
              end else if (h1_q == 4'd1 && h0_q == 4'd2) begin
                h1_d = 4'd0;
                h0_d = 4'd1;
              end
`else
              if (h1_q == 4'd2 && h0_q == 4'd3) begin
                h1_d = 4'd0;
                h0_d = 4'd0;
              end
`endif
              else if (h0_q == 4'd9) begin
                h1_d = h1_q + 4'd1;
                h0_d = 4'd0;
              end else h0_d = h0_q + 4'd1;
            end
          end
        end
      end
    end

    // A valid load overrides a coincident tick and restarts the second.
    if (bus.load) begin
      if (load_ok) begin
        h1_d        = bus.set_h1;
        h0_d        = bus.set_h0;
        m1_d        = bus.set_m1;
        m0_d        = bus.set_m0;
        s1_d        = 4'd0;
        s0_d        = 4'd0;
        pm_d        = set_pm_in;
        pre_d       = '0;
        sec_pulse_d = 1'b0;
      end else begin
        load_err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= STOPPED;
      pre_q       <= '0;
      h1_q        <= RST_H1;
      h0_q        <= RST_H0;
      m1_q        <= 4'd0;
      m0_q        <= 4'd0;
      s1_q        <= 4'd0;
      s0_q        <= 4'd0;
      pm_q        <= 1'b0;
      sec_pulse_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      h1_q        <= h1_d;
      h0_q        <= h0_d;
      m1_q        <= m1_d;
      m0_q        <= m0_d;
      s1_q        <= s1_d;
      s0_q        <= s0_d;
      pm_q        <= pm_d;
      sec_pulse_q <= sec_pulse_d;
      load_err_q  <= load_err_d;
    end
  end

  assign bus.h1        = h1_q;
  assign bus.h0        = h0_q;
  assign bus.m1        = m1_q;
  assign bus.m0        = m0_q;
  assign bus.s1        = s1_q;
  assign bus.s0        = s0_q;
  assign bus.sec_pulse = sec_pulse_q;
  assign bus.load_err  = load_err_q;
endmodule
